// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch program counter sequencer. Selects the next PC from branch,
//            jump, stall hold or sequential increment, and pulses the IF/ID
//            flush on redirect. The optional halt/resume state machine is
//            built only when PCSEQ_HALT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [10:0] RESET_PC = 11'd0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [10:0]      branch_pc_i,
    input  logic [31:0]      branch_offset_i,
    input  logic             jump_i,
    input  logic [10:0]      jump_target_i,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic [10:0]      pc_o,
    output logic [10:0]      pc_plus1_o,
    output logic             fetch_valid_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] fetch_count_o
);

`ifdef PCSEQ_HALT_EN
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [10:0]        pc_q, pc_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic               flush_q, flush_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [10:0]        w_pc_plus1;
    logic [10:0]        w_branch_target;
    logic               w_redirect;
    logic [10:0]        w_redirect_pc;

    // Only the low 11 offset bits matter in an 11-bit address space.
`ifdef PCSEQ_HALT_EN
    logic unused_offset_hi;
    assign unused_offset_hi = ^branch_offset_i[31:11];
`else
    logic unused_inputs;
    assign unused_inputs = ^{branch_offset_i[31:11], halt_i, resume_i};
`endif

    assign w_pc_plus1      = pc_q + 11'd1;
    assign w_branch_target = branch_pc_i + branch_offset_i[10:0];
    assign w_redirect      = branch_taken_i | jump_i;
    // The branch is the older instruction (EX vs ID), so it beats a jump.
    assign w_redirect_pc   = branch_taken_i ? w_branch_target : jump_target_i;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;

        if (w_redirect) begin
            pc_d    = w_redirect_pc;
            flush_d = 1'b1;
`ifdef PCSEQ_HALT_EN
            if (state_q == ST_HALT) begin
                state_d       = ST_HALT;
                fetch_valid_d = 1'b0;
            end else begin
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
            end
`else
            state_d       = ST_RUN;
            fetch_valid_d = 1'b1;
`endif
        end
`ifdef PCSEQ_HALT_EN
        else if (state_q == ST_HALT) begin
            if (resume_i && !halt_i) begin
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
            end else begin
                state_d       = ST_HALT;
                fetch_valid_d = 1'b0;
            end
        end
        else if (halt_i) begin
            state_d       = ST_HALT;
            fetch_valid_d = 1'b0;
        end
`endif
        else if (stall_i) begin
            state_d       = ST_STALL;
            fetch_valid_d = 1'b0;
        end
        else begin
            // Advance only past a PC that was actually fetched; a held PC
            // (after reset, stall or halt) is re-presented first.
            state_d       = ST_RUN;
            fetch_valid_d = 1'b1;
            if ((state_q == ST_RUN) && fetch_valid_q) begin
                pc_d = w_pc_plus1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (fetch_valid_d && !(&count_q)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            count_q       <= count_d;
        end
    end

    assign pc_o          = pc_q;
    assign pc_plus1_o    = w_pc_plus1;
    assign fetch_valid_o = fetch_valid_q;
    assign flush_o       = flush_q;
    assign fetch_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed self-checking bench for pc_sequencer (CNT_W=4 so the
//            fetch counter saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             stall_i;
    logic             branch_taken_i;
    logic [10:0]      branch_pc_i;
    logic [31:0]      branch_offset_i;
    logic             jump_i;
    logic [10:0]      jump_target_i;
    logic             halt_i;
    logic             resume_i;
    logic [10:0]      pc_o;
    logic [10:0]      pc_plus1_o;
    logic             fetch_valid_o;
    logic             flush_o;
    logic [CNT_W-1:0] fetch_count_o;

    int n_cmp;
    int n_err;

    pc_sequencer #(
        .RESET_PC (11'd0),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_pc_i     (branch_pc_i),
        .branch_offset_i (branch_offset_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .halt_i          (halt_i),
        .resume_i        (resume_i),
        .pc_o            (pc_o),
        .pc_plus1_o      (pc_plus1_o),
        .fetch_valid_o   (fetch_valid_o),
        .flush_o         (flush_o),
        .fetch_count_o   (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string tag, input logic [10:0] pc, input logic fv, input logic fl);
        check_eq({tag, ".pc"},    {21'd0, pc_o},          {21'd0, pc});
        check_eq({tag, ".valid"}, {31'd0, fetch_valid_o}, {31'd0, fv});
        check_eq({tag, ".flush"}, {31'd0, flush_o},       {31'd0, fl});
    endtask

    task automatic clear_inputs();
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_pc_i     = 11'd0;
        branch_offset_i = 32'd0;
        jump_i          = 1'b0;
        jump_target_i   = 11'd0;
        halt_i          = 1'b0;
        resume_i        = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        clear_inputs();

        // Reset held two cycles
        step();
        step();
        chk_pc("reset", 11'd0, 1'b0, 1'b0);
        check_eq("reset.count", {28'd0, fetch_count_o}, 32'd0);

        // Release: first edge re-presents RESET_PC as valid, no increment
        reset = 1'b0;
        step();
        chk_pc("rel0", 11'd0, 1'b1, 1'b0);
        step();
        chk_pc("rel1", 11'd1, 1'b1, 1'b0);
        step();
        step();
        chk_pc("rel3", 11'd3, 1'b1, 1'b0);
        check_eq("rel3.count", {28'd0, fetch_count_o}, 32'd4);
        check_eq("rel3.plus1", {21'd0, pc_plus1_o}, 32'd4);

        // Stall at pc=5 for three cycles
        step();
        step();
        chk_pc("pre_stall", 11'd5, 1'b1, 1'b0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_pc($sformatf("stall%0d", i), 11'd5, 1'b0, 1'b0);
        end
        check_eq("stall.count", {28'd0, fetch_count_o}, 32'd6);
        stall_i = 1'b0;
        step();
        chk_pc("unstall", 11'd5, 1'b1, 1'b0);
        step();
        chk_pc("unstall1", 11'd6, 1'b1, 1'b0);

        // Branch: 10 + (-4) = 6
        branch_taken_i  = 1'b1;
        branch_pc_i     = 11'd10;
        branch_offset_i = 32'hFFFF_FFFC;
        step();
        chk_pc("branch", 11'd6, 1'b1, 1'b1);
        clear_inputs();
        step();
        chk_pc("branch1", 11'd7, 1'b1, 1'b0);

        // Branch + jump + stall together: branch wins, 2+3 = 5
        branch_taken_i  = 1'b1;
        jump_i          = 1'b1;
        stall_i         = 1'b1;
        branch_pc_i     = 11'd2;
        branch_offset_i = 32'd3;
        jump_target_i   = 11'd100;
        step();
        chk_pc("combo", 11'd5, 1'b1, 1'b1);
        clear_inputs();
        step();
        chk_pc("combo1", 11'd6, 1'b1, 1'b0);

        // Wrap from 7FE
        jump_i        = 1'b1;
        jump_target_i = 11'h7FE;
        step();
        chk_pc("jump", 11'h7FE, 1'b1, 1'b1);
        clear_inputs();
        step();
        chk_pc("wrap0", 11'h7FF, 1'b1, 1'b0);
        check_eq("wrap0.plus1", {21'd0, pc_plus1_o}, 32'd0);
        step();
        chk_pc("wrap1", 11'd0, 1'b1, 1'b0);
        check_eq("wrap1.count", {28'd0, fetch_count_o}, 32'd15);

        // Offset upper bits ignored: 0 + 0x801 -> 1
        branch_taken_i  = 1'b1;
        branch_pc_i     = 11'd0;
        branch_offset_i = 32'h0000_0801;
        step();
        chk_pc("trunc", 11'd1, 1'b1, 1'b1);
        clear_inputs();
        step();
        chk_pc("trunc1", 11'd2, 1'b1, 1'b0);
        check_eq("sat.count", {28'd0, fetch_count_o}, 32'd15);

        // Back-to-back redirects keep flush high two cycles
        jump_i        = 1'b1;
        jump_target_i = 11'd20;
        step();
        chk_pc("bb0", 11'd20, 1'b1, 1'b1);
        jump_target_i = 11'd30;
        step();
        chk_pc("bb1", 11'd30, 1'b1, 1'b1);
        clear_inputs();
        step();
        chk_pc("bb2", 11'd31, 1'b1, 1'b0);

        // Reset wins while stalled
        stall_i = 1'b1;
        step();
        chk_pc("mid_stall", 11'd31, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk_pc("rst_stall", 11'd0, 1'b0, 1'b0);
        check_eq("rst_stall.count", {28'd0, fetch_count_o}, 32'd0);
        reset   = 1'b0;
        stall_i = 1'b0;
        step();
        chk_pc("rst_rel", 11'd0, 1'b1, 1'b0);

        // Advance to pc=8, then halt
        for (int i = 0; i < 8; i++) step();
        chk_pc("pre_halt", 11'd8, 1'b1, 1'b0);
        halt_i = 1'b1;
        step();
`ifdef PCSEQ_HALT_EN
        chk_pc("halt", 11'd8, 1'b0, 1'b0);
        halt_i = 1'b0;
        step();
        chk_pc("halted", 11'd8, 1'b0, 1'b0);
        resume_i = 1'b1;
        halt_i   = 1'b1;
        step();
        chk_pc("halt_wins", 11'd8, 1'b0, 1'b0);
        halt_i = 1'b0;
        step();
        chk_pc("resume", 11'd8, 1'b1, 1'b0);
        resume_i = 1'b0;
        step();
        chk_pc("resume1", 11'd9, 1'b1, 1'b0);
`else
        chk_pc("halt_ignored", 11'd9, 1'b1, 1'b0);
        halt_i   = 1'b0;
        resume_i = 1'b1;
        step();
        chk_pc("resume_ignored", 11'd10, 1'b1, 1'b0);
        resume_i = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
